instr_fetch_queue: RTL and testbench

Instruction fetch front end for the GPU processor core. Issues sequential reads to instruction memory, buffers returned 32-bit instructions with their PCs in a small prefetch FIFO, and presents them to the decode stage over a valid/ready handshake. Handles branch redirects by flushing, and stops fetching at the end instruction.

---
 rtl/instr_fetch_queue.sv | 124 ++++++++++++
 tb/tb_instr_fetch_queue.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: sequential imem reads feed a fall-through prefetch FIFO toward decode.
// Optional macro IFQ_END_DETECT_EN enables end-opcode (17) detection with DRAIN and HALT states.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] START_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] start_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        d_valid,
  output logic [31:0] d_instr,
  output logic [15:0] d_pc,
  input  logic        d_ready,
  output logic        busy,
  output logic        halted
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);
  localparam logic [4:0] OP_END = 5'd17;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]    state;
  logic [15:0]   fetch_pc;
  logic [15:0]   inflight_pc;
  logic          inflight;
  logic [31:0]   instr_mem [DEPTH];
  logic [15:0]   pc_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [AW+1:0] occupancy;
  logic          run;
  logic          flush;
  logic          take_start;
  logic          resp_en;
  logic          pop;
  logic          is_end;

  // Handshake: the head moves to decode on every rising edge with d_valid && d_ready;
  // d_valid never drops and the head never changes until accepted or flushed.
  assign run       = (state == S_RUN);
  assign busy      = run || (state == S_DRAIN);
  assign occupancy = {1'b0, count} + {{(AW+1){1'b0}}, inflight};
  assign imem_req  = run && (occupancy < DEPTH_W);
  assign imem_addr = fetch_pc;
  assign d_valid   = (count != '0);
  assign d_instr   = d_valid ? instr_mem[rd_ptr] : 32'h0;
  assign d_pc      = d_valid ? pc_mem[rd_ptr] : 16'h0;
  assign pop       = d_valid && d_ready;
  assign flush     = busy && redirect;

`ifdef IFQ_END_DETECT_EN
  assign take_start = start && ((state == S_IDLE) || (state == S_HALT));
  assign halted     = (state == S_HALT);
  assign is_end     = (imem_rdata[28:24] == OP_END);
`else
  assign take_start = start && (state == S_IDLE);
  assign halted     = 1'b0;
  assign is_end     = 1'b0;
`endif

  // Responses are only kept in RUN; DRAIN drops the one request made alongside the end word.
  assign resp_en = run && inflight && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      fetch_pc    <= START_PC;
      inflight    <= 1'b0;
      inflight_pc <= START_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (take_start || flush) begin
      state    <= S_RUN;
      fetch_pc <= take_start ? start_pc : redirect_pc;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 16'd1;
      end
      // The end word pins fetch_pc just past itself, overriding the same-cycle increment.
      if (resp_en && is_end) begin
        state    <= S_DRAIN;
        fetch_pc <= inflight_pc + 16'd1;
      end
      if ((state == S_DRAIN) && pop && (count == (AW+1)'(1)))
        state <= S_HALT;
      if (resp_en)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({resp_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (resp_en) begin
      instr_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]    <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: table-driven fetch/backpressure vectors plus redirect, reset and end sequences.
// Honours IFQ_END_DETECT_EN the same way the design does.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] start_pc = 16'h0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        d_valid;
  logic [31:0] d_instr;
  logic [15:0] d_pc;
  logic        d_ready = 1'b0;
  logic        busy;
  logic        halted;

  instr_fetch_queue #(.DEPTH(4), .START_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .start(start), .start_pc(start_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .d_valid(d_valid), .d_instr(d_instr), .d_pc(d_pc), .d_ready(d_ready),
    .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_xfer   = 0;
  int end_addr = -1;
  logic [47:0] exp_q[$];

  // Memory contents: constant field carries the address; one address may hold the end opcode.
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    logic [4:0] op;
    op = (int'(a) == end_addr) ? 5'd17 : {1'b0, a[3:0]};
    return {2'b01, a[4], op, 4'h3, 4'hC, a};
  endfunction

  // Read data valid exactly one cycle after the request; otherwise junk carrying the end opcode.
  always @(posedge clk)
    imem_rdata <= imem_req ? mem_word(imem_addr) : 32'h1100_BEEF;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard: every accepted head must match the oldest expected {pc, instr}.
  always @(negedge clk) begin
    if (!rst && d_valid && d_ready) begin
      n_xfer++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL xfer_unexpected: got pc %0h instr %0h with nothing expected", d_pc, d_instr);
      end else begin
        check("xfer", 64'({d_pc, d_instr}), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pc(input logic [15:0] p);
    exp_q.push_back({p, mem_word(p)});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},    64'(imem_req),  64'(0));
    check({tag, "_addr"},   64'(imem_addr), 64'(16'h0000));
    check({tag, "_valid"},  64'(d_valid),   64'(0));
    check({tag, "_instr"},  64'(d_instr),   64'(0));
    check({tag, "_pc"},     64'(d_pc),      64'(0));
    check({tag, "_busy"},   64'(busy),      64'(0));
    check({tag, "_halted"}, 64'(halted),    64'(0));
  endtask

  task automatic apply_reset();
    rst = 1'b1; start = 1'b0; redirect = 1'b0; d_ready = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    check_reset_outputs("rst");
  endtask

  task automatic do_start(input logic [15:0] pc);
    start = 1'b1;
    start_pc = pc;
    tick();
    start = 1'b0;
  endtask

  task automatic take_n(input int n, input int budget, output int cyc);
    int target;
    target = n_xfer + n;
    cyc = 0;
    d_ready = 1'b1;
    while (n_xfer < target && cyc < budget) begin
      tick();
      cyc++;
    end
    d_ready = 1'b0;
    check("take_count", 64'(n_xfer), 64'(target));
  endtask

  typedef struct {
    logic [15:0] start_pc;
    int          hold;
    int          take;
    logic        exp_valid;
    logic        exp_req;
    logic [15:0] exp_addr;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish (%0d/%0d)", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [15:0] nxt;

    // {start_pc, ready-low cycles, taken, d_valid, imem_req, imem_addr, cycles to take}
    vecs[0] = '{16'h0010, 0,  4, 1'b0, 1'b1, 16'h0010, 6};
    vecs[1] = '{16'h0100, 1,  5, 1'b0, 1'b1, 16'h0101, 6};
    vecs[2] = '{16'h0020, 2,  3, 1'b1, 1'b1, 16'h0022, 3};
    vecs[3] = '{16'h0040, 10, 8, 1'b1, 1'b0, 16'h0044, 8};
    vecs[4] = '{16'hFFFE, 10, 5, 1'b1, 1'b0, 16'h0002, 5};
    vecs[5] = '{16'h1234, 4,  4, 1'b1, 1'b0, 16'h1238, 4};

    for (int i = 0; i < 6; i++) begin
      apply_reset();
      for (int k = 0; k < vecs[i].take; k++)
        push_pc(vecs[i].start_pc + 16'(k));
      do_start(vecs[i].start_pc);
      repeat (vecs[i].hold) tick();
      check("vec_valid", 64'(d_valid),   64'(vecs[i].exp_valid));
      check("vec_req",   64'(imem_req),  64'(vecs[i].exp_req));
      check("vec_addr",  64'(imem_addr), 64'(vecs[i].exp_addr));
      take_n(vecs[i].take, 40, cyc);
      check("vec_cycles", 64'(cyc), 64'(vecs[i].exp_cycles));
      check("vec_q_empty", 64'(exp_q.size()), 64'(0));
    end

    // Redirect with three entries queued and one response in flight.
    apply_reset();
    do_start(16'h0300);
    repeat (4) tick();
    check("redir_pre_req",  64'(imem_req), 64'(0));
    check("redir_pre_head", 64'(d_pc),     64'(16'h0300));
    redirect = 1'b1;
    redirect_pc = 16'h0200;
    for (int k = 0; k < 3; k++) push_pc(16'h0200 + 16'(k));
    tick();
    redirect = 1'b0;
    check("redir_flush_valid", 64'(d_valid), 64'(0));
    check("redir_busy",        64'(busy),    64'(1));
    tick();
    check("redir_gap_valid", 64'(d_valid), 64'(0));
    tick();
    check("redir_first_valid", 64'(d_valid), 64'(1));
    check("redir_first_pc",    64'(d_pc),    64'(16'h0200));
    take_n(3, 20, cyc);
    check("redir_cycles", 64'(cyc), 64'(3));
    check("redir_q_empty", 64'(exp_q.size()), 64'(0));

    // Reset asserted with a response in flight, released before it returns.
    apply_reset();
    do_start(16'h0500);
    tick();
    tick();
    check("midrst_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    #2;
    rst = 1'b0;
    repeat (3) tick();
    check("midrst_after_valid", 64'(d_valid),  64'(0));
    check("midrst_after_busy",  64'(busy),     64'(0));
    check("midrst_after_req",   64'(imem_req), 64'(0));

    // End opcode at 0x05.
    end_addr = 5;
    apply_reset();
`ifdef IFQ_END_DETECT_EN
    for (int k = 2; k <= 5; k++) push_pc(16'(k));
    do_start(16'h0002);
    take_n(4, 30, cyc);
    check("end_cycles", 64'(cyc),       64'(6));
    check("end_halted", 64'(halted),    64'(1));
    check("end_busy",   64'(busy),      64'(0));
    check("end_valid",  64'(d_valid),   64'(0));
    check("end_req",    64'(imem_req),  64'(0));
    check("end_addr",   64'(imem_addr), 64'(16'h0006));
    repeat (3) tick();
    check("end_discard_valid", 64'(d_valid), 64'(0));
    check("end_still_halted",  64'(halted),  64'(1));
    end_addr = -1;
    push_pc(16'h0010);
    push_pc(16'h0011);
    do_start(16'h0010);
    check("restart_busy",   64'(busy),   64'(1));
    check("restart_halted", 64'(halted), 64'(0));
    take_n(2, 20, cyc);
    nxt = 16'h0012;
`else
    for (int k = 2; k <= 8; k++) push_pc(16'(k));
    do_start(16'h0002);
    take_n(7, 30, cyc);
    check("noend_halted", 64'(halted), 64'(0));
    check("noend_busy",   64'(busy),   64'(1));
    nxt = 16'h0009;
`endif

    // A start while running is ignored; sequential delivery continues.
    do_start(16'h0900);
    push_pc(nxt);
    push_pc(nxt + 16'd1);
    take_n(2, 20, cyc);
    check("ign_start_q_empty", 64'(exp_q.size()), 64'(0));
    check("ign_start_busy",    64'(busy),         64'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
